// File: rtl/exec_wb_unit.sv
// Execute/writeback stage: single-cycle ALU ops or a WIDTH-step shift-add multiply,
// then one register-file write cycle. Upstream is flow-controlled by in_valid/in_ready.
module exec_wb_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [REGW-1:0]  dest,
    output logic             enwr,
    output logic [WIDTH-1:0] wrdata,
    output logic [REGW-1:0]  regNum,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] prod_q;
    logic [CW-1:0]    count_q;
    logic [REGW-1:0]  dest_q;
    logic             enwr_q;
    logic [WIDTH-1:0] wrdata_q;
    logic [REGW-1:0]  regnum_q;

    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] prod_d;
    logic             slt;
    op_t              op_in;

    assign op_in = op_t'(op);
    assign slt   = $signed(rdata1) < $signed(rdata2);

    always_comb begin
        alu_d = '0;
        case (op_in)
            OP_ADD:  alu_d = rdata1 + rdata2;
            OP_SUB:  alu_d = rdata1 - rdata2;
            OP_AND:  alu_d = rdata1 & rdata2;
            OP_OR:   alu_d = rdata1 | rdata2;
            OP_XOR:  alu_d = rdata1 ^ rdata2;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, slt};
            default: alu_d = '0;
        endcase
    end

    // One shift-add step; its result is also what lands in wrdata on the last step.
    assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            dest_q   <= '0;
            enwr_q   <= 1'b0;
            wrdata_q <= '0;
            regnum_q <= '0;
        end else begin
            enwr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op_in == OP_MUL) begin
                            mcand_q  <= rdata1;
                            mplier_q <= rdata2;
                            prod_q   <= '0;
                            count_q  <= '0;
                            dest_q   <= dest;
                            state_q  <= S_MUL;
                        end else begin
                            wrdata_q <= alu_d;
                            regnum_q <= dest;
                            enwr_q   <= (op_in != OP_NOP) && (dest != '0);
                            state_q  <= S_WB;
                        end
                    end
                end
                S_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        wrdata_q <= prod_d;
                        regnum_q <= dest_q;
                        enwr_q   <= (dest_q != '0);
                        state_q  <= S_WB;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // rst_n gates ready so nothing looks acceptable during a reset cycle.
    assign in_ready = rst_n && (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign enwr     = enwr_q;
    assign wrdata   = wrdata_q;
    assign regNum   = regnum_q;

endmodule

// File: tb/tb_exec_wb_unit.sv
// Self-checking bench for exec_wb_unit: transaction-level reference model compared
// every cycle, plus directed cases with hand-computed results and randomized traffic.
module tb_exec_wb_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  dest;
    logic        enwr;
    logic [31:0] wrdata;
    logic [4:0]  regNum;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    exec_wb_unit #(.WIDTH(32), .REGW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dest     (dest),
        .enwr     (enwr),
        .wrdata   (wrdata),
        .regNum   (regNum),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        case (o)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: one instruction in flight; write lands at the accept edge
    // (single-cycle) or 32 edges later (MUL); the unit frees up one edge after the write.
    bit          mdl_on = 1'b0;
    bit          m_active = 1'b0;
    int          m_wb_edge = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_dest = '0;
    bit          m_we = 1'b0;
    int          cyc = 0;
    bit          exp_enwr = 1'b0;
    logic [31:0] exp_wrdata = '0;
    logic [4:0]  exp_regnum = '0;

    always @(posedge clk) begin : model
        automatic bit          act = m_active;
        automatic int          wb = m_wb_edge;
        automatic logic [31:0] res = m_res;
        automatic logic [4:0]  d = m_dest;
        automatic bit          we = m_we;
        cyc <= cyc + 1;
        if (!rst_n) begin
            mdl_on     <= 1'b1;
            m_active   <= 1'b0;
            exp_enwr   <= 1'b0;
            exp_wrdata <= '0;
            exp_regnum <= '0;
        end else begin
            if (!act && in_valid) begin
                act = 1'b1;
                res = ref_result(op, rdata1, rdata2);
                d   = dest;
                we  = (op != 3'd7) && (dest != 5'd0);
                wb  = cyc + ((op == 3'd6) ? 32 : 0);
            end else if (act && cyc == wb + 1) begin
                act = 1'b0;
            end
            exp_enwr <= act && (cyc == wb) && we;
            if (act && cyc == wb) begin
                exp_wrdata <= res;
                exp_regnum <= d;
            end
            m_active  <= act;
            m_wb_edge <= wb;
            m_res     <= res;
            m_dest    <= d;
            m_we      <= we;
        end
    end

    always @(negedge clk) begin : compare
        if (mdl_on) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, rst_n && !m_active});
            check("busy", {31'd0, busy}, {31'd0, m_active});
            check("enwr", {31'd0, enwr}, {31'd0, exp_enwr});
            if (exp_enwr) begin
                check("wrdata", wrdata, exp_wrdata);
                check("regNum", {27'd0, regNum}, {27'd0, exp_regnum});
            end
        end
    end

    // Presents an op and holds it until an edge where in_ready was high.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        bit r;
        bit acc = 1'b0;
        in_valid = 1'b1;
        op = o;
        rdata1 = a;
        rdata2 = b;
        dest = d;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r && rst_n) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; observes the write pulse and busy window.
    task automatic wait_done(input bit exp_we, input logic [31:0] exp_data,
                             input logic [4:0] exp_reg, input int exp_wn, input int exp_busy,
                             input string nm);
        int we_cnt = 0;
        int we_n = 0;
        int busy_cnt = 0;
        int done = 0;
        logic [31:0] d = '0;
        logic [4:0]  r = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (enwr) begin
                if (we_cnt == 0) begin
                    we_n = n;
                    d = wrdata;
                    r = regNum;
                end
                we_cnt++;
            end
            if (in_ready) begin
                done = n;
                break;
            end
        end
        check({nm, "_done"}, {31'd0, done != 0}, 32'd1);
        check({nm, "_writes"}, we_cnt, exp_we ? 32'd1 : 32'd0);
        check({nm, "_busy_cycles"}, busy_cnt, exp_busy);
        if (exp_we) begin
            check({nm, "_data"}, d, exp_data);
            check({nm, "_reg"}, {27'd0, r}, {27'd0, exp_reg});
            check({nm, "_latency"}, we_n, exp_wn);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pulses;
        rst_n = 1'b0;
        in_valid = 1'b0;
        op = '0;
        rdata1 = '0;
        rdata2 = '0;
        dest = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_enwr", {31'd0, enwr}, 32'd0);
        check("reset_wrdata", wrdata, 32'd0);
        check("reset_regNum", {27'd0, regNum}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        issue(3'd0, 32'd64, 32'd31, 5'd10);
        wait_done(1'b1, 32'h0000_005F, 5'd10, 1, 1, "add");
        issue(3'd1, 32'd31, 32'd64, 5'd14);
        wait_done(1'b1, 32'hFFFF_FFDF, 5'd14, 1, 1, "sub");
        issue(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd2);
        wait_done(1'b1, 32'd1, 5'd2, 1, 1, "slt_neg");
        issue(3'd5, 32'd1, 32'hFFFF_FFFF, 5'd3);
        wait_done(1'b1, 32'd0, 5'd3, 1, 1, "slt_pos");
        issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4);
        wait_done(1'b1, 32'hF000_F000, 5'd4, 1, 1, "and");
        issue(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5);
        wait_done(1'b1, 32'hFFF0_FFF0, 5'd5, 1, 1, "or");
        issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6);
        wait_done(1'b1, 32'h0FF0_0FF0, 5'd6, 1, 1, "xor");
        issue(3'd6, 32'd45, 32'd31, 5'd19);
        wait_done(1'b1, 32'd1395, 5'd19, 33, 33, "mul_45x31");
        issue(3'd6, 32'hFFFF_FFFF, 32'd2, 5'd20);
        wait_done(1'b1, 32'hFFFF_FFFE, 5'd20, 33, 33, "mul_wrap");
        issue(3'd6, 32'd12345, 32'd0, 5'd21);
        wait_done(1'b1, 32'd0, 5'd21, 33, 33, "mul_zero");
        issue(3'd0, 32'd1, 32'd2, 5'd0);
        wait_done(1'b0, 32'd0, 5'd0, 0, 1, "add_dest0");
        issue(3'd7, 32'd9, 32'd9, 5'd5);
        wait_done(1'b0, 32'd0, 5'd0, 0, 1, "nop");

        // Second op presented with in_valid held high through the whole MUL.
        issue(3'd6, 32'd7, 32'd9, 5'd3);
        issue(3'd0, 32'd100, 32'd23, 5'd4);
        wait_done(1'b1, 32'd123, 5'd4, 1, 1, "held_valid");

        // Reset asserted for one edge at the tenth MUL cycle.
        issue(3'd6, 32'd45, 32'd31, 5'd19);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (enwr) pulses++;
        end
        check("abort_no_write", pulses, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_wrdata", wrdata, 32'd0);
        check("abort_regNum", {27'd0, regNum}, 32'd0);
        issue(3'd0, 32'd2, 32'd3, 5'd8);
        wait_done(1'b1, 32'd5, 5'd8, 1, 1, "post_abort_add");

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h8000_0000;
                1: b = 32'd1;
                default: b = $urandom;
            endcase
            issue(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
